// File: rtl/pivot_partition.sv
// Quickselect partition stage: streams samples against a pivot, counts lower/equal/larger
// classes with their extremes, and hands over one registered record. Optional tag stream: PART_TAG_EN.
module pivot_partition #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               in_pivot,
    input  logic [BUFF_SIZE_BIT-1:0] in_count,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BUFF_SIZE_BIT-1:0] lower_size,
    output logic [BUFF_SIZE_BIT-1:0] equal_size,
    output logic [BUFF_SIZE_BIT-1:0] larger_size,
    output logic [7:0]               max_lower,
    output logic [7:0]               min_lower,
    output logic [7:0]               max_larger,
    output logic [7:0]               min_larger
`ifdef PART_TAG_EN
    ,
    output logic                     tag_valid,
    output logic [1:0]               tag_class,
    output logic [7:0]               tag_data
`endif
);

    // state  | meaning
    // IDLE   | waiting for start; last record still visible on the outputs
    // LOAD   | accepting samples until the latched count is reached
    // DONE   | record valid, held until out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [BUFF_SIZE_BIT-1:0] MAX_CNT = BUFF_SIZE_BIT'(BUFF_SIZE);

    state_t                   state, state_nxt;
    logic [7:0]               pivot_q;
    logic [BUFF_SIZE_BIT-1:0] count_q;
    logic [BUFF_SIZE_BIT-1:0] cnt_q;
    logic [BUFF_SIZE_BIT-1:0] count_clamped;
    logic                     start_ok;
    logic                     accept;
    logic                     last_accept;

    assign count_clamped = (in_count > MAX_CNT) ? MAX_CNT : in_count;
    assign start_ok      = (state == S_IDLE) && start;
    assign accept        = (state == S_LOAD) && in_valid;
    assign last_accept   = accept && ((cnt_q + BUFF_SIZE_BIT'(1)) == count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (count_clamped == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_accept) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pivot_q     <= 8'h00;
            count_q     <= '0;
            cnt_q       <= '0;
            lower_size  <= '0;
            equal_size  <= '0;
            larger_size <= '0;
            max_lower   <= 8'h00;
            min_lower   <= 8'hFF;
            max_larger  <= 8'h00;
            min_larger  <= 8'hFF;
        end else if (start_ok) begin
            pivot_q     <= in_pivot;
            count_q     <= count_clamped;
            cnt_q       <= '0;
            lower_size  <= '0;
            equal_size  <= '0;
            larger_size <= '0;
            max_lower   <= 8'h00;
            min_lower   <= 8'hFF;
            max_larger  <= 8'h00;
            min_larger  <= 8'hFF;
        end else if (accept) begin
            cnt_q <= cnt_q + BUFF_SIZE_BIT'(1);
            if (in_data < pivot_q) begin
                lower_size <= lower_size + BUFF_SIZE_BIT'(1);
                if (in_data < min_lower) min_lower <= in_data;
                if (in_data > max_lower) max_lower <= in_data;
            end else if (in_data == pivot_q) begin
                equal_size <= equal_size + BUFF_SIZE_BIT'(1);
            end else begin
                larger_size <= larger_size + BUFF_SIZE_BIT'(1);
                if (in_data < min_larger) min_larger <= in_data;
                if (in_data > max_larger) max_larger <= in_data;
            end
        end
    end

`ifdef PART_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= 1'b0;
            tag_class <= 2'b00;
            tag_data  <= 8'h00;
        end else begin
            tag_valid <= accept;
            if (accept) begin
                tag_data  <= in_data;
                tag_class <= (in_data < pivot_q)  ? 2'b00 :
                             (in_data == pivot_q) ? 2'b01 : 2'b10;
            end
        end
    end
`endif

endmodule

// File: doc/pivot_partition.md
Name: pivot_partition

Overview:
- Upstream neighbour of the next-iteration selection logic in the median datapath.
- For one quickselect iteration it streams up to BUFF_SIZE 8-bit samples and compares each against the current pivot.
- Accumulates lower/equal/larger counts plus min/max of the lower and larger classes.
- Presents the result as one registered record with a valid/ready handshake.

Parameters:
- BUFF_SIZE, 32, maximum samples per iteration.
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of every count/size field (holds BUFF_SIZE itself).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin iteration; sampled only in IDLE.
- in_pivot  in  8  pivot for this iteration, latched on accepted start.
- in_count  in  BUFF_SIZE_BIT  number of samples to consume, latched on accepted start.
- in_data  in  8  sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts sample this cycle.
- busy  out  1  high in LOAD or DONE.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer takes record.
- lower_size, equal_size, larger_size  out  BUFF_SIZE_BIT  class counts.
- max_lower, min_lower, max_larger, min_larger  out  8  class extremes.

Behaviour:
- Reset: async on rst_n low. State IDLE; in_ready=0, busy=0, out_valid=0; all sizes 0; min_* = 8'hFF; max_* = 8'h00; latched pivot/count 0.
- Reset mid-operation discards the partial iteration with no record produced.
- IDLE:
  - in_ready=0.
  - On start=1, latch pivot and count.
  - Clamp count: if in_count>BUFF_SIZE, use BUFF_SIZE.
  - Clear accumulators to their reset values.
  - Next state: LOAD if count>0; DONE if count==0, giving an all-zero-size record with empty-class extremes.
- LOAD:
  - in_ready=1 combinationally from state.
  - Accept when in_valid&&in_ready.
  - Per accepted sample d:
    - d<pivot: lower_size+1, min_lower=min(min_lower,d), max_lower=max(max_lower,d).
    - d==pivot: equal_size+1.
    - d>pivot: larger_size+1, with larger extremes updated the same way.
  - Unsigned compare.
  - Sample counter increments per accept.
  - When the accept that makes counter==count occurs, next state is DONE; in_ready deasserts next cycle.
  - in_valid gaps stall without side effects.
- DONE:
  - out_valid=1, record stable and held until out_ready=1.
  - On out_valid&&out_ready, go to IDLE the next cycle; outputs retain their values until the next accepted start.
- start is ignored outside IDLE, including a start asserted in the same cycle as the DONE handshake.
- Latency: start at cycle 0, continuous in_valid, count N gives accepts in cycles 1..N and out_valid in cycle N+1.
- Invariant at DONE: lower_size+equal_size+larger_size == latched count.
- Empty class keeps min=FF, max=00. The downstream stage relies on the size fields, not the extremes, for empty classes.
- Counters cannot overflow: clamped count ≤ BUFF_SIZE fits in BUFF_SIZE_BIT.

Optional Feature:
- Macro PART_TAG_EN.
- Defined: adds outputs tag_valid(1), tag_class(2), tag_data(8).
  - Registered one cycle after each accepted sample.
  - tag_class: 00 lower, 01 equal, 10 larger.
  - tag_data is the sample.
  - Reset value 0 on all three.
  - Used to write partition buffers downstream.
  - No backpressure on the tag stream.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Pivot 100, count 5, samples 50,100,150,20,200 continuous -> out_valid at cycle 6. Record: lower=2, equal=1, larger=2, min_lower=20, max_lower=50, min_larger=150, max_larger=200.
- Pivot 7, count 4, all samples 7 with in_valid toggling every other cycle -> equal=4, lower=larger=0, min_*=FF, max_*=00. Exactly 4 accepts.
- Count 0 with start -> DONE at cycle 1, all sizes 0, no in_ready pulse.
- in_count=40 with BUFF_SIZE=32, pivot 0, samples 1..32 -> accepts exactly 32, then larger=32, min_larger=1, max_larger=32. in_ready low after the 32nd accept.
- Hold out_ready=0 for 10 cycles in DONE while pulsing start -> record stable and no restart. Release -> IDLE next cycle, after which a new start is accepted.
- Assert rst_n low after 3 of 8 samples -> outputs return to reset values immediately. A new iteration afterwards produces a correct record. With PART_TAG_EN, tag_class sequence checked against the first scenario: 00,01,10,00,10.
